wbu_commit_arb: RTL
===================

# wbu_commit_arb

Write-back and commit arbiter for long instructions. Collects completed results from the ALU, MUL, DIV and CSR execution units, each tagged with the commit ID issued at dispatch. Serialises them onto the single register-file write port. Returns one `commit_valid_o`/`commit_id_o` pulse per retired instruction to the hazard detection unit, which frees the matching scoreboard slot.

## Interface
Parameters:
- `NUM_SRC`, 4: number of result sources, fixed order 0=ALU, 1=MUL, 2=DIV, 3=CSR; the only supported value.
- `REG_ADDR_WIDTH`, `` `REG_ADDR_WIDTH `` (5): destination register address width.
- `REG_DATA_WIDTH`, `` `REG_DATA_WIDTH `` (32): result data width.
- `COMMIT_ID_WIDTH`, `` `COMMIT_ID_WIDTH `` (3): commit tag width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `src_valid_i`  in  NUM_SRC  source s presents a result.
- `src_ready_o`  out  NUM_SRC  source s may transfer this cycle.
- `src_rd_we_i`  in  NUM_SRC  result writes a register.
- `src_rd_addr_i`  in  NUM_SRC×REG_ADDR_WIDTH  destination register, packed, source 0 in the low bits.
- `src_rd_data_i`  in  NUM_SRC×REG_DATA_WIDTH  result data.
- `src_commit_id_i`  in  NUM_SRC×COMMIT_ID_WIDTH  tag issued by the hazard unit.
- `reg_we_o`  out  1  register-file write enable.
- `reg_waddr_o`  out  REG_ADDR_WIDTH  write address.
- `reg_wdata_o`  out  REG_DATA_WIDTH  write data.
- `commit_valid_o`  out  1  one long instruction retired.
- `commit_id_o`  out  COMMIT_ID_WIDTH  tag of the retired instruction.

## Operation
- Each source has a one-entry holding register containing valid, we, addr, data and id.
- `src_ready_o[s] = ~hold_valid[s] | grant[s]`.
  - A transfer occurs when `src_valid_i[s] & src_ready_o[s]` are both high.
  - The transfer loads the holding register at the clock edge.
- Arbitration is combinational over `hold_valid`.
  - At most one `grant` bit is set per cycle.
  - `grant` is all-zero when no entry is held.
- Granted entry:
  - Is copied into the output registers.
  - Clears its `hold_valid`, unless a new transfer for the same source occurs in the same cycle; then the entry is reloaded and stays valid.
- Output register contents:
  - `commit_valid_o <= 1` and `commit_id_o <= id`.
  - `reg_we_o <= we & (addr != 0)`; writes to x0 are suppressed but still commit.
  - `reg_waddr_o <= addr` and `reg_wdata_o <= data`.
- With no grant, `commit_valid_o` and `reg_we_o` are 0 the next cycle. Address, data and id outputs hold their last values.
- A result with `rd_we = 0` still produces a commit pulse with `reg_we_o = 0`.
- No tag checking is performed; uniqueness of in-flight IDs is the dispatch side's responsibility.

## Timing
- Reset values: `commit_valid_o=0`, `commit_id_o=0`, `reg_we_o=0`, `reg_waddr_o=0`, `reg_wdata_o=0`. All `hold_valid=0`, round-robin pointer = 3, so source 0 has highest priority first.
- Reset asserted mid-operation discards all held results without any commit pulse.
- `src_ready_o` is all-ones in the first cycle after reset.
- Latency:
  - A transfer at edge N is held during cycle N+1.
  - If granted in cycle N+1, the outputs assert during cycle N+2 for exactly one cycle.
  - Minimum latency from valid to commit is 2 cycles.
- Throughput is one commit per cycle sustained. A single source streaming back-to-back retires one result per cycle, because `ready` stays high through `grant`.
- A source whose entry is held and not granted sees `ready=0`. It must keep `valid` and its payload stable until accepted.
- Simultaneous pending entries are served one per cycle in arbitration order. Losers keep their entries untouched.

## Configuration
- `WBU_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at the source after the last granted one (wrap 3→0).
  - The pointer updates only on a grant.
  - Any source waits at most 3 cycles once held.
- `WBU_ROUND_ROBIN_EN` undefined: fixed priority ALU > MUL > DIV > CSR; no pointer register.
  - Lower-priority sources may starve under continuous ALU traffic.

## Test plan
- Reset, then MUL presents we=1, addr=5, data=0x1234, id=2 for one cycle → ready=1 and transfer at edge N. Two cycles later, for one cycle: `reg_we_o=1`, `reg_waddr_o=5`, `reg_wdata_o=0x1234`, `commit_valid_o=1`, `commit_id_o=2`.
- DIV result with addr=0, we=1, id=4 → `commit_valid_o=1`, `commit_id_o=4`, `reg_we_o=0`; CSR result with we=0, id=6 → commit pulse with id 6, `reg_we_o=0`.
- All four sources present simultaneously with ids 0,1,2,3 → four consecutive commit pulses.
  - With the macro: ids 0,1,2,3.
  - Without the macro: ids 0,1,2,3 as well.
  - While waiting, non-granted `src_ready_o` bits are 0.
- ALU streams 6 back-to-back results while DIV holds one (id=7).
  - With the macro: id 7 commits no later than the 2nd cycle after its entry is held.
  - Without the macro: id 7 commits only after the ALU stream ends.
- ALU sends ids 0,1,2 on consecutive cycles → `src_ready_o[0]` stays 1, and commits with ids 0,1,2 appear on three consecutive cycles.
- Hold entries in all sources, assert `rst_n=0` for one cycle → no commit pulse, all outputs 0, `src_ready_o=4'b1111` after release.

Source files
------------

// File: rtl/wbu_commit_arb.sv
// wbu_commit_arb: write-back and commit arbiter for long instructions.
//
// Collects completed results from the ALU(0), MUL(1), DIV(2) and CSR(3) units
// into one-entry holding registers. It serialises them onto the single
// register-file write port and emits one commit pulse per retired instruction.
//
// Configuration macro: WBU_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration over held entries
//   undefined -> fixed priority ALU > MUL > DIV > CSR
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   src_valid_i/ready_o per-source valid/ready handshake
//   src_rd_we_i         per-source register write request
//   src_rd_addr_i       packed destination addresses, source 0 in low bits
//   src_rd_data_i       packed result data
//   src_commit_id_i     packed commit tags
//   reg_we_o/waddr_o/wdata_o  registered register-file write port
//   commit_valid_o/id_o       registered retire pulse and tag

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 3
`endif

module wbu_commit_arb #(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned REG_ADDR_WIDTH  = `REG_ADDR_WIDTH,
  parameter int unsigned REG_DATA_WIDTH  = `REG_DATA_WIDTH,
  parameter int unsigned COMMIT_ID_WIDTH = `COMMIT_ID_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  output logic [NUM_SRC-1:0]                   src_ready_o,
  input  logic [NUM_SRC-1:0]                   src_rd_we_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    src_rd_addr_i,
  input  logic [NUM_SRC*REG_DATA_WIDTH-1:0]    src_rd_data_i,
  input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0]   src_commit_id_i,
  output logic                                 reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0]            reg_waddr_o,
  output logic [REG_DATA_WIDTH-1:0]            reg_wdata_o,
  output logic                                 commit_valid_o,
  output logic [COMMIT_ID_WIDTH-1:0]           commit_id_o
);

  // Holding registers, one entry per source.
  logic [NUM_SRC-1:0]                      hold_valid_q, hold_valid_d;
  logic [NUM_SRC-1:0]                      hold_we_q, hold_we_d;
  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
  logic [NUM_SRC-1:0][REG_DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [NUM_SRC-1:0][COMMIT_ID_WIDTH-1:0] hold_id_q, hold_id_d;

  // Output registers.
  logic                       reg_we_q, reg_we_d;
  logic [REG_ADDR_WIDTH-1:0]  reg_waddr_q, reg_waddr_d;
  logic [REG_DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
  logic                       commit_valid_q, commit_valid_d;
  logic [COMMIT_ID_WIDTH-1:0] commit_id_q, commit_id_d;

  logic [NUM_SRC-1:0] grant;

`ifdef WBU_ROUND_ROBIN_EN
  localparam int unsigned PtrW = $clog2(NUM_SRC);

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] rr_idx;

  // Search starts one past the last granted source; k == NUM_SRC wraps back
  // onto the pointer itself, so the last winner is considered last.
  always_comb begin
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      rr_idx = rr_ptr_q + PtrW'(k);
      if ((grant == '0) && hold_valid_q[rr_idx]) begin
        grant[rr_idx] = 1'b1;
        rr_ptr_d      = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= PtrW'(NUM_SRC - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Isolate the lowest set bit: source 0 wins over higher indices.
  always_comb begin
    grant = hold_valid_q & ~(hold_valid_q - NUM_SRC'(1));
  end
`endif

  // A granted entry frees its slot this cycle, so its source may refill it.
  assign src_ready_o = ~hold_valid_q | grant;

  // Select the granted entry's payload.
  logic                       sel_we;
  logic [REG_ADDR_WIDTH-1:0]  sel_addr;
  logic [REG_DATA_WIDTH-1:0]  sel_data;
  logic [COMMIT_ID_WIDTH-1:0] sel_id;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_id   = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (grant[s]) begin
        sel_we   = hold_we_q[s];
        sel_addr = hold_addr_q[s];
        sel_data = hold_data_q[s];
        sel_id   = hold_id_q[s];
      end
    end
  end

  // Holding register next state: a transfer reloads (even when granted),
  // otherwise a grant clears the entry.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_id_d    = hold_id_q;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (src_valid_i[s] && src_ready_o[s]) begin
        hold_valid_d[s] = 1'b1;
        hold_we_d[s]    = src_rd_we_i[s];
        hold_addr_d[s]  = src_rd_addr_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        hold_data_d[s]  = src_rd_data_i[s*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        hold_id_d[s]    = src_commit_id_i[s*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
      end else if (grant[s]) begin
        hold_valid_d[s] = 1'b0;
      end
    end
  end

  // Output next state; address/data/id hold their last values when idle.
  always_comb begin
    commit_valid_d = |grant;
    // Writes to x0 are dropped but the instruction still commits.
    reg_we_d       = (|grant) & sel_we & (sel_addr != '0);
    reg_waddr_d    = reg_waddr_q;
    reg_wdata_d    = reg_wdata_q;
    commit_id_d    = commit_id_q;
    if (|grant) begin
      reg_waddr_d = sel_addr;
      reg_wdata_d = sel_data;
      commit_id_d = sel_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q   <= '0;
      hold_we_q      <= '0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
      hold_id_q      <= '0;
      reg_we_q       <= 1'b0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
    end else begin
      hold_valid_q   <= hold_valid_d;
      hold_we_q      <= hold_we_d;
      hold_addr_q    <= hold_addr_d;
      hold_data_q    <= hold_data_d;
      hold_id_q      <= hold_id_d;
      reg_we_q       <= reg_we_d;
      reg_waddr_q    <= reg_waddr_d;
      reg_wdata_q    <= reg_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
    end
  end

  assign reg_we_o       = reg_we_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign reg_wdata_o    = reg_wdata_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_id_o    = commit_id_q;

endmodule
